// File: rtl/gain_coeff_ctrl.sv
// Gain coefficient controller: accumulates per-channel peaks over NFRAME frames,
// derives a 16-bit window LSB index with hysteresis, and applies it at frame_start.
module gain_coeff_ctrl #(
  parameter int NFRAME      = 4,
  parameter int HEADROOM    = 1,
  parameter int HYST        = 1,
  parameter int RESET_COEFF = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        auto_en,
  input  logic [15:0] man_coeff_I,
  input  logic [15:0] man_coeff_Q,
  input  logic [15:0] man_coeff_U,
  input  logic [15:0] man_coeff_V,
  input  logic [47:0] max_I,
  input  logic [47:0] max_Q,
  input  logic [47:0] max_U,
  input  logic [47:0] max_V,
  output logic [15:0] scaled_coeff_I,
  output logic [15:0] scaled_coeff_Q,
  output logic [15:0] scaled_coeff_U,
  output logic [15:0] scaled_coeff_V,
  output logic        coeff_upd,
  output logic        busy,
  output logic        ovf
);

  localparam int                FW        = $clog2(NFRAME);
  localparam logic [FW-1:0]     FCNT_LAST = FW'(NFRAME - 1);
  localparam logic [5:0]        RST_C     = 6'(RESET_COEFF);
  localparam logic [5:0]        COEFF_MAX = 6'd32;
  localparam logic signed [8:0] TGT_OFS   = 9'(HEADROOM - 15);
  localparam logic signed [8:0] TGT_MAX   = 9'sd32;
  localparam logic [6:0]        HYST_W    = 7'(HYST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [3:0][47:0]  peak_q, peak_d;
  logic [3:0][47:0]  work_q, work_d;
  logic [3:0][5:0]   res_q, res_d;
  logic [3:0][5:0]   shadow_q, shadow_d;
  logic [3:0][5:0]   active_q, active_d;
  logic              pending_q, pending_d;
  logic              upd_q, upd_d;
  logic              ovf_q, ovf_d;

  logic [3:0][47:0]  max_in;
  logic [3:0][15:0]  man_in;
  logic [3:0][47:0]  pk_max;
  logic              is_dec;

  logic [47:0]       scan_work;
  logic [5:0]        scan_cur;
  logic [5:0]        msb_idx;
  logic              msb_vld;
  logic signed [8:0] tgt_raw;
  logic [5:0]        tgt;
  logic [6:0]        drop;
  logic [5:0]        new_coeff;

  assign max_in = {max_V, max_U, max_Q, max_I};
  assign man_in = {man_coeff_V, man_coeff_U, man_coeff_Q, man_coeff_I};

  // Peak tracking and frame counting
  always_comb begin
    is_dec = frame_end && (fcnt_q == FCNT_LAST);
    fcnt_d = fcnt_q;
    peak_d = peak_q;
    for (int unsigned c = 0; c < 4; c++) begin
      pk_max[c] = (max_in[c] > peak_q[c]) ? max_in[c] : peak_q[c];
    end
    if (frame_end) begin
      fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FW'(1);
      peak_d = is_dec ? '0 : pk_max;
    end
  end

  // Per-channel target: leading-one position plus headroom, clamped to 0..32
  always_comb begin
    scan_work = work_q[ch_q];
    scan_cur  = active_q[ch_q];
    msb_idx   = '0;
    msb_vld   = 1'b0;
    for (int unsigned i = 0; i < 48; i++) begin
      if (scan_work[i]) begin
        msb_idx = 6'(i);
        msb_vld = 1'b1;
      end
    end
    tgt_raw = $signed({3'b000, msb_idx}) + TGT_OFS;
    if (!msb_vld || tgt_raw[8]) begin
      tgt = '0;
    end else if (tgt_raw > TGT_MAX) begin
      tgt = COEFF_MAX;
    end else begin
      tgt = tgt_raw[5:0];
    end
    drop = '0;
    if (tgt > scan_cur) begin
      new_coeff = tgt;
    end else begin
      drop      = {1'b0, scan_cur - tgt};
      new_coeff = (drop > HYST_W) ? tgt : scan_cur;
    end
  end

  // FSM, shadow and active coefficient update
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    work_d    = work_q;
    res_d     = res_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (is_dec) begin
          work_d  = pk_max;
          ch_d    = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        res_d[ch_q] = new_coeff;
        ch_d        = ch_q + 2'd1;
        if (ch_q == 2'd3) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (is_dec && (state_q != IDLE)) begin
      ovf_d = 1'b1;
    end

    if (frame_start) begin
      if (auto_en) begin
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        for (int unsigned c = 0; c < 4; c++) begin
          active_d[c] = (man_in[c] > 16'd32) ? COEFF_MAX : man_in[c][5:0];
        end
        pending_d = 1'b0;
      end
    end

    // A commit coinciding with frame_start must survive the apply's pending clear
    if (state_q == COMMIT) begin
      shadow_d  = res_q;
      pending_d = 1'b1;
    end

    upd_d = (active_d != active_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      fcnt_q    <= '0;
      peak_q    <= '0;
      work_q    <= '0;
      res_q     <= '0;
      shadow_q  <= {4{RST_C}};
      active_q  <= {4{RST_C}};
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      fcnt_q    <= fcnt_d;
      peak_q    <= peak_d;
      work_q    <= work_d;
      res_q     <= res_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign scaled_coeff_I = {10'b0, active_q[0]};
  assign scaled_coeff_Q = {10'b0, active_q[1]};
  assign scaled_coeff_U = {10'b0, active_q[2]};
  assign scaled_coeff_V = {10'b0, active_q[3]};
  assign coeff_upd      = upd_q;
  assign busy           = (state_q != IDLE);
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_gain_coeff_ctrl.sv
// Bench for gain_coeff_ctrl: directed scenarios plus randomized traffic against a
// time-based reference model, run on NFRAME=4 and NFRAME=2 instances in parallel.
module tb_gain_coeff_ctrl;

  localparam int HR = 1;
  localparam int HY = 1;
  localparam int RC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             frame_start = 1'b0;
  logic             frame_end = 1'b0;
  logic             auto_en = 1'b1;
  logic [3:0][15:0] man = '0;
  logic [3:0][47:0] mx = '0;

  logic [3:0][15:0] q1, q2;
  logic             upd1, upd2, busy1, busy2, ovf1, ovf2;
  logic [3:0][15:0] dq[2];
  logic             du[2], db[2], dov[2];

  assign dq[0] = q1;   assign dq[1] = q2;
  assign du[0] = upd1; assign du[1] = upd2;
  assign db[0] = busy1; assign db[1] = busy2;
  assign dov[0] = ovf1; assign dov[1] = ovf2;

  gain_coeff_ctrl #(.NFRAME(4), .HEADROOM(HR), .HYST(HY), .RESET_COEFF(RC)) u_dut4 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end), .auto_en(auto_en),
    .man_coeff_I(man[0]), .man_coeff_Q(man[1]), .man_coeff_U(man[2]), .man_coeff_V(man[3]),
    .max_I(mx[0]), .max_Q(mx[1]), .max_U(mx[2]), .max_V(mx[3]),
    .scaled_coeff_I(q1[0]), .scaled_coeff_Q(q1[1]), .scaled_coeff_U(q1[2]), .scaled_coeff_V(q1[3]),
    .coeff_upd(upd1), .busy(busy1), .ovf(ovf1));

  gain_coeff_ctrl #(.NFRAME(2), .HEADROOM(HR), .HYST(HY), .RESET_COEFF(RC)) u_dut2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end), .auto_en(auto_en),
    .man_coeff_I(man[0]), .man_coeff_Q(man[1]), .man_coeff_U(man[2]), .man_coeff_V(man[3]),
    .max_I(mx[0]), .max_Q(mx[1]), .max_U(mx[2]), .max_V(mx[3]),
    .scaled_coeff_I(q2[0]), .scaled_coeff_Q(q2[1]), .scaled_coeff_U(q2[2]), .scaled_coeff_V(q2[3]),
    .coeff_upd(upd2), .busy(busy2), .ovf(ovf2));

  // Reference model: decisions are timestamped; channel c is resolved c+1 edges
  // after the decision, results land in the shadow 5 edges after it.
  int          nfr[2] = '{4, 2};
  int          m_act[2][4], m_sh[2][4], m_res[2][4];
  logic [47:0] m_peak[2][4], m_work[2][4];
  int          m_fcnt[2], m_dec[2];
  bit          m_pend[2], m_upd[2], m_ovf[2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int tgt(input logic [47:0] w);
    int msb = -1;
    int t;
    for (int i = 0; i < 48; i++) if (w[i]) msb = i;
    if (msb < 0) return 0;
    t = msb + 1 + HR - 16;
    if (t < 0) t = 0;
    if (t > 32) t = 32;
    return t;
  endfunction

  function automatic int hyst(input int t, input int cur);
    if (t > cur) return t;
    if (cur - t > HY) return t;
    return cur;
  endfunction

  function automatic bit m_busy(input int k);
    return (cyc - 1 - m_dec[k] >= 0) && (cyc - 1 - m_dec[k] <= 4);
  endfunction

  task automatic model_step(input int k);
    int off;
    int nact[4];
    bit npend;
    bit dec;
    logic [47:0] m;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        m_act[k][c] = RC; m_sh[k][c] = RC; m_peak[k][c] = '0; m_work[k][c] = '0;
      end
      m_fcnt[k] = 0; m_pend[k] = 0; m_upd[k] = 0; m_ovf[k] = 0; m_dec[k] = -100;
      return;
    end
    off = cyc - m_dec[k];
    if (off >= 1 && off <= 4)
      m_res[k][off-1] = hyst(tgt(m_work[k][off-1]), m_act[k][off-1]);
    for (int c = 0; c < 4; c++) nact[c] = m_act[k][c];
    npend = m_pend[k];
    if (frame_start) begin
      if (auto_en) begin
        if (m_pend[k]) begin
          for (int c = 0; c < 4; c++) nact[c] = m_sh[k][c];
          npend = 0;
        end
      end else begin
        for (int c = 0; c < 4; c++) nact[c] = (man[c] > 32) ? 32 : int'(man[c]);
        npend = 0;
      end
    end
    if (off == 5) begin
      for (int c = 0; c < 4; c++) m_sh[k][c] = m_res[k][c];
      npend = 1;
    end
    m_upd[k] = 0;
    for (int c = 0; c < 4; c++) if (nact[c] != m_act[k][c]) m_upd[k] = 1;
    if (frame_end) begin
      dec = (m_fcnt[k] == nfr[k] - 1);
      for (int c = 0; c < 4; c++) begin
        m = (mx[c] > m_peak[k][c]) ? mx[c] : m_peak[k][c];
        if (dec) begin
          if (!(off >= 1 && off <= 5)) m_work[k][c] = m;
          m_peak[k][c] = '0;
        end else begin
          m_peak[k][c] = m;
        end
      end
      if (dec) begin
        if (off >= 1 && off <= 5) m_ovf[k] = 1;
        else m_dec[k] = cyc;
      end
      m_fcnt[k] = (m_fcnt[k] + 1) % nfr[k];
    end
    for (int c = 0; c < 4; c++) m_act[k][c] = nact[c];
    m_pend[k] = npend;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic run_frames(input logic [47:0] mi, input logic [47:0] mq,
                            input logic [47:0] mu, input logic [47:0] mv, input int nf);
    mx = {mv, mu, mq, mi};
    repeat (nf) begin
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      repeat (7) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (q1[c] !== 16'd16) begin
        n_bad++; $display("FAIL reset_coeff[%0d]: got %0d expected 16", c, q1[c]);
      end
    end
    n_cmp++;
    if ({upd1, busy1, ovf1, upd2, busy2, ovf2} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 000000", {upd1, busy1, ovf1, upd2, busy2, ovf2});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_auto();
    int cnt = 0;
    auto_en = 1'b1;
    run_frames(48'h0000_FFFF_0000, '0, '0, '0, 4);
    n_cmp++;
    if (q1[0] !== 16'd16) begin
      n_bad++; $display("FAIL basic_hold_before_fs: got %0d expected 16", q1[0]);
    end
    pulse_fs();
    n_cmp++;
    if (q1 !== {16'd0, 16'd0, 16'd0, 16'd17}) begin
      n_bad++; $display("FAIL basic_coeffs: got %h expected 0000000000000011", q1);
    end
    n_cmp++;
    if (upd1 !== 1'b1) begin
      n_bad++; $display("FAIL basic_upd: got %b expected 1", upd1);
    end
    repeat (6) begin
      tick();
      if (upd1) cnt++;
    end
    n_cmp++;
    if (cnt != 0) begin
      n_bad++; $display("FAIL basic_upd_once: got %0d extra pulses expected 0", cnt);
    end
  endtask

  task automatic test_clamp_latency();
    mx = {48'd0, 48'h100, 48'h8000_0000_0000, 48'h0000_FFFF_0000};
    run_frames(mx[0], mx[1], mx[2], mx[3], 3);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_bad++; $display("FAIL lat_busy: got %b expected 1", busy1);
    end
    repeat (4) tick();
    pulse_fs();
    n_cmp++;
    if (upd1 !== 1'b0 || q1[1] !== 16'd0) begin
      n_bad++; $display("FAIL lat_commit_fs: got upd=%b Q=%0d expected upd=0 Q=0", upd1, q1[1]);
    end
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++; $display("FAIL lat_idle: got %b expected 0", busy1);
    end
    repeat (3) tick();
    pulse_fs();
    n_cmp++;
    if (q1 !== {16'd0, 16'd0, 16'd32, 16'd17} || upd1 !== 1'b1) begin
      n_bad++; $display("FAIL clamp_coeffs: got %h upd=%b expected 0000000000200011 upd=1", q1, upd1);
    end
  endtask

  task automatic test_hysteresis();
    int tg[4] = '{20, 19, 18, 21};
    int ex[4] = '{20, 20, 18, 21};
    bit eu[4] = '{1, 0, 1, 1};
    logic [47:0] w;
    for (int r = 0; r < 4; r++) begin
      w = 48'd1 << (tg[r] + 14);
      run_frames(w, 48'h8000_0000_0000, 48'h100, '0, 4);
      pulse_fs();
      n_cmp++;
      if (q1[0] !== 16'(ex[r]) || upd1 !== eu[r]) begin
        n_bad++;
        $display("FAIL hyst_t%0d: got I=%0d upd=%b expected I=%0d upd=%b", tg[r], q1[0], upd1, ex[r], eu[r]);
      end
    end
  endtask

  task automatic test_manual();
    int cnt = 0;
    auto_en = 1'b0;
    man = {16'd33, 16'd32, 16'd5, 16'd40};
    pulse_fs();
    n_cmp++;
    if (q1 !== {16'd32, 16'd32, 16'd5, 16'd32} || upd1 !== 1'b1) begin
      n_bad++; $display("FAIL manual_sat: got %h upd=%b expected 0020002000050020 upd=1", q1, upd1);
    end
    man[0] = 16'd3;
    repeat (5) begin
      tick();
      if (upd1 || q1[0] !== 16'd32) cnt++;
    end
    n_cmp++;
    if (cnt != 0) begin
      n_bad++; $display("FAIL manual_hold: got %0d changed cycles expected 0", cnt);
    end
    pulse_fs();
    n_cmp++;
    if (q1[0] !== 16'd3 || upd1 !== 1'b1) begin
      n_bad++; $display("FAIL manual_apply: got I=%0d upd=%b expected I=3 upd=1", q1[0], upd1);
    end
  endtask

  task automatic test_overrun();
    auto_en = 1'b1;
    mx = {48'd0, 48'd0, 48'd0, 48'd1 << 40};
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    repeat (7) tick();
    frame_end = 1'b1; tick();
    mx[0] = 48'd1 << 45;
    tick(); tick();
    frame_end = 1'b0;
    n_cmp++;
    if (ovf2 !== 1'b1 || ovf1 !== 1'b0 || busy2 !== 1'b1) begin
      n_bad++; $display("FAIL overrun_flags: got ovf2=%b ovf1=%b busy2=%b expected 1 0 1", ovf2, ovf1, busy2);
    end
    repeat (8) tick();
    pulse_fs();
    n_cmp++;
    if (q2[0] !== 16'd26 || q1[0] !== 16'd31) begin
      n_bad++; $display("FAIL overrun_commit: got I2=%0d I1=%0d expected 26 31", q2[0], q1[0]);
    end
    run_frames(48'd1 << 36, '0, '0, '0, 1);
    run_frames(48'd1 << 30, '0, '0, '0, 1);
    pulse_fs();
    n_cmp++;
    if (q2[0] !== 16'd22 || ovf2 !== 1'b1) begin
      n_bad++; $display("FAIL overrun_accum: got I2=%0d ovf2=%b expected 22 1", q2[0], ovf2);
    end
  endtask

  task automatic test_reset_mid_scan();
    run_frames(48'd1 << 20, '0, '0, '0, 2);
    run_frames(48'd1 << 44, 48'd1 << 44, 48'd1 << 44, 48'd1 << 44, 3);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if (q1 !== {4{16'd16}} || busy1 !== 1'b0 || ovf1 !== 1'b0 || ovf2 !== 1'b0) begin
      n_bad++; $display("FAIL rst_scan_state: got %h busy=%b ovf=%b ovf2=%b expected all 16, 0 0 0", q1, busy1, ovf1, ovf2);
    end
    repeat (8) tick();
    pulse_fs();
    n_cmp++;
    if (upd1 !== 1'b0 || q1 !== {4{16'd16}}) begin
      n_bad++; $display("FAIL rst_scan_no_apply: got %h upd=%b expected all 16 upd=0", q1, upd1);
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      auto_en     = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 5) == 0);
      frame_end   = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 4; c++) begin
        r = {$urandom(), $urandom()};
        mx[c] = r[47:0] >> $urandom_range(0, 47);
        if ($urandom_range(0, 9) == 0) mx[c] = '0;
        man[c] = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 40));
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          n_cmp++;
          if (dq[k][c] !== 16'(m_act[k][c])) begin
            n_bad++; $display("FAIL rand_coeff k%0d c%0d cyc%0d: got %0d expected %0d", k, c, cyc, dq[k][c], m_act[k][c]);
          end
        end
        n_cmp++;
        if (du[k] !== m_upd[k] || db[k] !== m_busy(k) || dov[k] !== m_ovf[k]) begin
          n_bad++;
          $display("FAIL rand_flags k%0d cyc%0d: got upd/busy/ovf=%b%b%b expected %b%b%b",
                   k, cyc, du[k], db[k], dov[k], m_upd[k], m_busy(k), m_ovf[k]);
        end
      end
    end
    rst = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_auto();
    test_clamp_latency();
    test_hysteresis();
    test_manual();
    test_overrun();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gain_coeff_ctrl.md
GAIN_COEFF_CTRL -- requirements
Module: gain_coeff_ctrl

Interface
REQ-001 Parameter NFRAME, default 4: frames per auto-scale decision (2..256).
REQ-002 Parameter HEADROOM, default 1: guard bits kept above the peak's leading one.
REQ-003 Parameter HYST, default 1: downward-change hysteresis, in coefficient steps.
REQ-004 Parameter RESET_COEFF, default 16: coefficient value loaded at reset.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 frame_start  in  1  1-cycle pulse at the start of an integration frame; this is the only point where active coefficients change.
REQ-008 frame_end  in  1  1-cycle pulse; max_* are valid in this cycle.
REQ-009 auto_en  in  1  1 = auto-scale, 0 = manual; sampled only at frame_start.
REQ-010 man_coeff_I/Q/U/V  in  16 each  host-programmed coefficients for manual mode.
REQ-011 max_I/Q/U/V  in  48 each  unsigned per-frame peak magnitude from each gain channel.
REQ-012 scaled_coeff_I/Q/U/V  out  16 each  active coefficient, the LSB index of the 16-bit window taken from the 48-bit word, range 0..32.
REQ-013 coeff_upd  out  1  1-cycle pulse when any active coefficient changed value.
REQ-014 busy  out  1  high while the FSM is not in IDLE.
REQ-015 ovf  out  1  sticky flag: a decision point was dropped because the FSM was busy.

Function
REQ-016 Peak accumulation: on each frame_end, peak_x <= max(peak_x, max_x) for every channel, and frame counter fcnt increments modulo NFRAME.
REQ-017 Decision point: frame_end with fcnt==NFRAME-1 copies max(peak_x, max_x) into work_x, clears peak_x to 0, and moves the FSM IDLE->SCAN.
REQ-018 FSM states: IDLE, SCAN, COMMIT. SCAN lasts exactly 4 cycles and processes one channel per cycle in the order I,Q,U,V. COMMIT lasts 1 cycle and returns to IDLE.
REQ-019 SCAN per channel: msb is the index of the highest set bit of work_x; target = msb+1+HEADROOM-16, evaluated signed and clamped to 0..32. work_x==0 gives target 0.
REQ-020 Hysteresis against the current active value cur: if target>cur the new value is target; if cur-target>HYST the new value is target; otherwise the new value is cur.
REQ-021 COMMIT writes the 4 results to shadow registers and sets pending=1.
REQ-022 Apply in auto mode: on frame_start with auto_en=1 and pending=1, active<=shadow and pending<=0. With pending=0, active is held.
REQ-023 Apply in manual mode: on frame_start with auto_en=0, active<=man_coeff_x masked to 0..32 (values >32 saturate to 32), and pending<=0.
REQ-024 coeff_upd is asserted in the cycle after the frame_start that changed at least one active value, coincident with the new outputs. It is not asserted if no value changed.
REQ-025 Decision-point latency: frame_end -> shadow valid at +6 cycles (4 SCAN + 1 COMMIT + register). Outputs then change only at the next frame_start.
REQ-026 A decision-point frame_end while busy=1 is dropped and sets ovf=1. Peak accumulation and fcnt still update normally.
REQ-027 frame_start and frame_end in the same cycle are each processed independently per REQ-016..024.
REQ-028 A frame_start during SCAN or COMMIT applies only a previously pending shadow. A COMMIT coinciding with frame_start writes shadow and applies at the following frame_start.
REQ-029 All arithmetic is unsigned 48-bit for peaks. Coefficient math is 7-bit signed before the clamp. Outputs are zero-extended to 16 bits.

Reset
REQ-030 While rst=1: scaled_coeff_* = RESET_COEFF, shadow = RESET_COEFF, peak_* = 0, work_* = 0, fcnt = 0, pending = 0, FSM = IDLE, coeff_upd = 0, busy = 0, ovf = 0.
REQ-031 rst asserted mid-SCAN or mid-COMMIT aborts the scan with no shadow write. Only rst clears ovf.

Verification
REQ-032 Basic auto decision: NFRAME=4, HEADROOM=1, auto_en=1; 4 frames with max_I peaking at 0x0000_FFFF_0000 -> after the next frame_start scaled_coeff_I=17 and coeff_upd pulses once.
REQ-033 Clamp bounds: max_Q=2^47 -> 32; max_U=0x100 -> 0; max_V=0 -> 0.
REQ-034 Hysteresis: cur=20, then target 19 -> stays 20 with no coeff_upd; target 18 -> becomes 18; target 21 -> becomes 21 immediately.
REQ-035 Manual mode: auto_en=0, man_coeff_I=40 -> 32 at frame_start; no output change between frame_starts even if man_coeff changes.
REQ-036 Overrun: decision frame_end, then a second decision frame_end 2 cycles later (NFRAME=2) -> ovf=1, first result still committed, peaks still accumulate.
REQ-037 Reset mid-SCAN: rst pulsed in the 2nd SCAN cycle -> all outputs = 16, busy=0, no coeff_upd at the next frame_start.
